// File: rtl/liteic_qos_arbiter.sv
// ============================================================================
// Module  : liteic_qos_arbiter
// Brief   : Per-slave-slot QoS arbiter, round-robin tie-break, aging.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package liteic_pkg;
  localparam int IC_NUM_MASTER_SLOTS = 4;
endpackage

module liteic_qos_arbiter
  import liteic_pkg::*;
#(
  parameter int N_MST        = IC_NUM_MASTER_SLOTS,
  parameter int QOS_W        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [N_MST-1:0]         req_valid_i,
  input  logic [QOS_W-1:0]         req_qos_i [N_MST],
  input  logic                     addr_hs_i,
  input  logic                     resp_hs_i,
  output logic [N_MST-1:0]         grant_o,
  output logic [$clog2(N_MST)-1:0] grant_idx_o,
  output logic                     grant_valid_o,
  output logic                     busy_o
);

  localparam int IDX_W = $clog2(N_MST);
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [IDX_W-1:0] C_LAST  = IDX_W'(N_MST - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_latch;
  logic               w_release;
  logic [N_MST-1:0]   r_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_cnt [N_MST];
  logic [N_MST-1:0]   w_starved;
  logic [N_MST-1:0]   w_top;
  logic [N_MST-1:0]   w_cand;
  logic [QOS_W-1:0]   w_max_qos;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_found;
  int                 w_scan;

  generate
    for (genvar i = 0; i < N_MST; i++) begin : g_starve
      assign w_starved[i] = (STARVE_LIMIT != 0) && (r_cnt[i] == C_LIMIT) && req_valid_i[i];
      assign w_top[i]     = req_valid_i[i] && (req_qos_i[i] == w_max_qos);
    end
  endgenerate

  always_comb begin
    w_max_qos = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (req_valid_i[i] && (req_qos_i[i] > w_max_qos)) begin
        w_max_qos = req_qos_i[i];
      end
    end
  end

  // Starved requesters take precedence over QoS; rr_ptr breaks ties in both cases.
  always_comb begin
    w_cand    = (|w_starved) ? w_starved : w_top;
    w_win_idx = '0;
    w_found   = 1'b0;
    w_scan    = 0;
    for (int k = 0; k < N_MST; k++) begin
      w_scan = (int'(r_rr_ptr) + k) % N_MST;
      if (!w_found && w_cand[w_scan]) begin
        w_found   = 1'b1;
        w_win_idx = IDX_W'(w_scan);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid_i) begin
          w_latch     = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (addr_hs_i && resp_hs_i) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (addr_hs_i) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_hs_i) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else if (w_latch) begin
      r_grant     <= N_MST'(1) << w_win_idx;
      r_grant_idx <= w_win_idx;
    end else if (w_release) begin
      r_grant  <= '0;
      r_rr_ptr <= (r_grant_idx == C_LAST) ? '0 : r_grant_idx + 1'b1;
    end
  end

  // Aging keeps running while another master owns the slot.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < N_MST; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_MST; i++) begin
        if (!req_valid_i[i] || (w_latch && (w_win_idx == IDX_W'(i)))) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != C_LIMIT) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign grant_o       = r_grant;
  assign grant_idx_o   = r_grant_idx;
  assign grant_valid_o = (r_state != S_IDLE);
  assign busy_o        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_liteic_qos_arbiter.sv
// ============================================================================
// Module  : tb_liteic_qos_arbiter
// Brief   : Directed self-checking bench for liteic_qos_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_liteic_qos_arbiter;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [3:0] req_valid_i = '0;
  logic [3:0] req_qos_i [4];
  logic       addr_hs_i = 1'b0;
  logic       resp_hs_i = 1'b0;

  logic [3:0] grant_o,       grant_s;
  logic [1:0] grant_idx_o,   grant_idx_s;
  logic       grant_valid_o, grant_valid_s;
  logic       busy_o,        busy_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  liteic_qos_arbiter #(.N_MST(4), .QOS_W(4), .STARVE_LIMIT(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_qos_i(req_qos_i),
    .addr_hs_i(addr_hs_i), .resp_hs_i(resp_hs_i), .grant_o(grant_o),
    .grant_idx_o(grant_idx_o), .grant_valid_o(grant_valid_o), .busy_o(busy_o)
  );

  liteic_qos_arbiter #(.N_MST(4), .QOS_W(4), .STARVE_LIMIT(4)) dut_s (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_qos_i(req_qos_i),
    .addr_hs_i(addr_hs_i), .resp_hs_i(resp_hs_i), .grant_o(grant_s),
    .grant_idx_o(grant_idx_s), .grant_valid_o(grant_valid_s), .busy_o(busy_s)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_qos(input logic [3:0] q3, input logic [3:0] q2,
                         input logic [3:0] q1, input logic [3:0] q0);
    req_qos_i[3] = q3; req_qos_i[2] = q2; req_qos_i[1] = q1; req_qos_i[0] = q0;
  endtask

  task automatic apply_reset();
    rstn_i = 1'b0; req_valid_i = '0; addr_hs_i = 1'b0; resp_hs_i = 1'b0;
    set_qos(0, 0, 0, 0);
    step(); step();
    rstn_i = 1'b1;
  endtask

  // Address and response handshake in one cycle, then back to no handshake.
  task automatic finish_txn();
    addr_hs_i = 1'b1; resp_hs_i = 1'b1;
    step();
    addr_hs_i = 1'b0; resp_hs_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (grant_o !== 4'b0000 || busy_o !== 1'b0 || grant_valid_o !== 1'b0 || grant_idx_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: grant=%b busy=%b gv=%b idx=%0d, want 0000 0 0 0",
               grant_o, busy_o, grant_valid_o, grant_idx_o);
    end
    req_valid_i = 4'b0100;
    step();
    checks++;
    if (grant_o !== 4'b0100 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_grant: grant=%b busy=%b, want 0100 1", grant_o, busy_o);
    end
    #3 rstn_i = 1'b0;
    #1;
    checks++;
    if (grant_o !== 4'b0000 || busy_o !== 1'b0 || grant_valid_o !== 1'b0 || grant_idx_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_async: grant=%b busy=%b gv=%b idx=%0d, want 0000 0 0 0",
               grant_o, busy_o, grant_valid_o, grant_idx_o);
    end
    req_valid_i = 4'b0000;
    step();
    rstn_i = 1'b1;
    step();
    checks++;
    if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: grant=%b busy=%b, want 0000 0", grant_o, busy_o);
    end
    set_qos(5, 5, 5, 5);
    req_valid_i = 4'b1111;
    step();
    checks++;
    if (grant_o !== 4'b0001 || grant_idx_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_rr_ptr: grant=%b idx=%0d, want 0001 0", grant_o, grant_idx_o);
    end
  endtask

  task automatic test_single_request();
    apply_reset();
    set_qos(3, 3, 3, 3);
    req_valid_i = 4'b0010;
    checks++;
    if (grant_o !== 4'b0000) begin
      failures++;
      $display("FAIL single_latency: grant=%b, want 0000", grant_o);
    end
    step();
    checks++;
    if (grant_o !== 4'b0010 || grant_idx_o !== 2'd1 || grant_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: grant=%b idx=%0d gv=%b busy=%b, want 0010 1 1 1",
               grant_o, grant_idx_o, grant_valid_o, busy_o);
    end
    addr_hs_i = 1'b1;
    step();
    req_valid_i = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      // addr_hs_i stays high in RESP and must not end the transaction.
      checks++;
      if (grant_o !== 4'b0010 || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL single_hold_%0d: grant=%b busy=%b, want 0010 1", c, grant_o, busy_o);
      end
      step();
    end
    addr_hs_i = 1'b0;
    resp_hs_i = 1'b1;
    checks++;
    if (grant_o !== 4'b0010) begin
      failures++;
      $display("FAIL single_hold_last: grant=%b, want 0010", grant_o);
    end
    step();
    resp_hs_i = 1'b0;
    checks++;
    if (grant_o !== 4'b0000 || busy_o !== 1'b0 || grant_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_release: grant=%b busy=%b gv=%b, want 0000 0 0",
               grant_o, busy_o, grant_valid_o);
    end
  endtask

  task automatic test_qos_priority();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0100; exp_g[2] = 4'b0010;
    apply_reset();
    set_qos(2, 9, 9, 1);
    req_valid_i = 4'b1111;
    for (int t = 0; t < 3; t++) begin
      step();
      checks++;
      if (grant_o !== exp_g[t]) begin
        failures++;
        $display("FAIL qos_grant_%0d: grant=%b, want %b", t, grant_o, exp_g[t]);
      end
      finish_txn();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    apply_reset();
    set_qos(5, 5, 5, 5);
    req_valid_i = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      step();
      checks++;
      if (grant_o !== exp_g[t]) begin
        failures++;
        $display("FAIL rr_grant_%0d: grant=%b, want %b", t, grant_o, exp_g[t]);
      end
      finish_txn();
      checks++;
      if (grant_o !== 4'b0000) begin
        failures++;
        $display("FAIL rr_gap_%0d: grant=%b, want 0000", t, grant_o);
      end
    end
  endtask

  task automatic test_starvation();
    logic [3:0] exp_g [4];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0010; exp_g[2] = 4'b0001; exp_g[3] = 4'b0010;
    apply_reset();
    set_qos(0, 0, 15, 0);
    req_valid_i = 4'b0011;
    for (int t = 0; t < 4; t++) begin
      step();
      checks++;
      if (grant_s !== exp_g[t]) begin
        failures++;
        $display("FAIL starve_grant_%0d: grant=%b, want %b", t, grant_s, exp_g[t]);
      end
      finish_txn();
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_qos(7, 7, 7, 7);
    req_valid_i = 4'b0100;
    step();
    checks++;
    if (grant_o !== 4'b0100 || grant_idx_o !== 2'd2) begin
      failures++;
      $display("FAIL b2b_grant: grant=%b idx=%0d, want 0100 2", grant_o, grant_idx_o);
    end
    req_valid_i = 4'b0000;
    finish_txn();
    checks++;
    if (grant_o !== 4'b0000 || busy_o !== 1'b0 || grant_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: grant=%b busy=%b gv=%b, want 0000 0 0",
               grant_o, busy_o, grant_valid_o);
    end
    req_valid_i = 4'b1111;
    step();
    checks++;
    if (grant_o !== 4'b1000 || grant_idx_o !== 2'd3) begin
      failures++;
      $display("FAIL b2b_rr_advance: grant=%b idx=%0d, want 1000 3", grant_o, grant_idx_o);
    end
  endtask

  initial begin
    set_qos(0, 0, 0, 0);
    test_reset();
    test_single_request();
    test_qos_priority();
    test_round_robin();
    test_starvation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
